// File: rtl/vip_bbox_pkg.sv
// Shared definitions for the binary bounding-box detector and the frame
// coordinate counter: FSM state encoding, pixel-count width and saturation
// value, and the default image geometry.
package vip_bbox_pkg;

  typedef enum logic [1:0] {
    ST_SYNC   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_ACTIVE = 2'd2,
    ST_LATCH  = 2'd3
  } bbox_state_t;

  localparam int              CNT_W   = 20;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  localparam int DEF_IMG_W   = 1024;
  localparam int DEF_IMG_H   = 640;
  localparam int DEF_EDGE    = 10;
  localparam int DEF_MIN_PIX = 64;

endpackage

// File: rtl/vip_frame_xy_counter.sv
// Pixel coordinate generator for a vsync/href/clken video stream.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   vsync, href, clken  frame window, line window, pixel qualifier
//   x, y                coordinates of the pixel presented this cycle
//   xy_ok               x and y are inside the image (not saturated past it)
//   vs_rise, vs_fall    vsync edges, valid in the cycle the new level arrives
//   hs_fall             href falling edge (end of line)
// x saturates at IMG_W-1 and y at IMG_H-1; pixels arriving after the last
// column or after the last line are flagged out of range through xy_ok.
module vip_frame_xy_counter #(
  parameter int IMG_W = 1024,
  parameter int IMG_H = 640,
  parameter int XW    = 11,
  parameter int YW    = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          vsync,
  input  logic          href,
  input  logic          clken,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic          xy_ok,
  output logic          vs_rise,
  output logic          vs_fall,
  output logic          hs_fall
);

  localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);

  logic vsync_d;
  logic href_d;
  logic x_ovf;
  logic y_ovf;

  assign vs_rise = vsync & ~vsync_d;
  assign vs_fall = ~vsync & vsync_d;
  assign hs_fall = ~href & href_d;
  assign xy_ok   = ~x_ovf & ~y_ovf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_d <= 1'b0;
      href_d  <= 1'b0;
      x       <= '0;
      y       <= '0;
      x_ovf   <= 1'b0;
      y_ovf   <= 1'b0;
    end else begin
      vsync_d <= vsync;
      href_d  <= href;
      if (vs_rise) begin
        x     <= '0;
        x_ovf <= 1'b0;
        y     <= '0;
        y_ovf <= 1'b0;
      end else if (hs_fall) begin
        x     <= '0;
        x_ovf <= 1'b0;
        if (y == Y_LAST) y_ovf <= 1'b1;
        else             y     <= y + 1'b1;
      end else if (clken && href) begin
        // Once the last column has been consumed, x stays put and the
        // overflow flag marks every further pixel of the line as outside.
        if (x == X_LAST) x_ovf <= 1'b1;
        else             x     <= x + 1'b1;
      end
    end
  end

endmodule

// File: rtl/vip_bit_bbox_detector.sv
// Bounding box of all '1' pixels of a binary video frame.
// The box, pixel count and valid flag are latched once per frame when vsync
// falls; the video stream is passed through with one clock of delay.
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   per_frame_vsync/href/clken      input stream control
//   per_img_Bit                     input binary pixel (1 = object)
//   post_frame_vsync/href/clken     stream control delayed by 1 clk
//   post_img_Bit                    pixel delayed by 1 clk
//   bbox_xmin/xmax, bbox_ymin/ymax  latched box
//   bbox_pix_cnt                    latched '1' pixel count (saturating)
//   bbox_valid                      latched count >= MIN_PIX
//   frame_done                      1-clk pulse when the latched outputs update
// Build option VIP_BBOX_HOLD_EN: when defined, a frame with too few pixels
// keeps the previous box and bbox_valid; only the count and frame_done update.
module vip_bit_bbox_detector
  import vip_bbox_pkg::*;
#(
  parameter int IMG_W   = DEF_IMG_W,
  parameter int IMG_H   = DEF_IMG_H,
  parameter int EDGE    = DEF_EDGE,
  parameter int MIN_PIX = DEF_MIN_PIX,
  parameter int XW      = 11,
  parameter int YW      = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             per_frame_vsync,
  input  logic             per_frame_href,
  input  logic             per_frame_clken,
  input  logic             per_img_Bit,
  output logic             post_frame_vsync,
  output logic             post_frame_href,
  output logic             post_frame_clken,
  output logic             post_img_Bit,
  output logic [XW-1:0]    bbox_xmin,
  output logic [XW-1:0]    bbox_xmax,
  output logic [YW-1:0]    bbox_ymin,
  output logic [YW-1:0]    bbox_ymax,
  output logic [CNT_W-1:0] bbox_pix_cnt,
  output logic             bbox_valid,
  output logic             frame_done
);

  localparam logic [XW-1:0]    X_IDLE  = XW'(IMG_W - 1);
  localparam logic [YW-1:0]    Y_IDLE  = YW'(IMG_H - 1);
  localparam logic [XW-1:0]    X_EDGE  = XW'(EDGE);
  localparam logic [YW-1:0]    Y_EDGE  = YW'(EDGE);
  localparam logic [CNT_W-1:0] CNT_MIN = CNT_W'(MIN_PIX);

  bbox_state_t      state, state_nxt;
  logic             acc_clr, frame_end, hit;
  logic [XW-1:0]    x;
  logic [YW-1:0]    y;
  logic             xy_ok, vs_rise, vs_fall, hs_fall;
  logic [XW-1:0]    acc_xmin, acc_xmax;
  logic [YW-1:0]    acc_ymin, acc_ymax;
  logic [CNT_W-1:0] acc_cnt;

  vip_frame_xy_counter #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H),
    .XW    (XW),
    .YW    (YW)
  ) u_xy (
    .clk     (clk),
    .rst_n   (rst_n),
    .vsync   (per_frame_vsync),
    .href    (per_frame_href),
    .clken   (per_frame_clken),
    .x       (x),
    .y       (y),
    .xy_ok   (xy_ok),
    .vs_rise (vs_rise),
    .vs_fall (vs_fall),
    .hs_fall (hs_fall)
  );

  // The cycle that closes a line never carries a pixel.
  assign hit = per_frame_clken & per_frame_href & per_img_Bit & ~hs_fall & xy_ok
             & (x >= X_EDGE) & (y >= Y_EDGE) & (state == ST_ACTIVE);

  assign frame_done = (state == ST_LATCH);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_SYNC;
    else        state <= state_nxt;
  end

  // SYNC waits out any frame already running at reset release.
  // A vsync rise seen while ACTIVE means the fall was missed: restart.
  always_comb begin
    state_nxt = state;
    acc_clr   = 1'b0;
    frame_end = 1'b0;
    case (state)
      ST_SYNC:   if (!per_frame_vsync) state_nxt = ST_WAIT;
      ST_WAIT:   if (vs_rise) begin
                   acc_clr   = 1'b1;
                   state_nxt = ST_ACTIVE;
                 end
      ST_ACTIVE: if (vs_rise) begin
                   acc_clr = 1'b1;
                 end else if (vs_fall) begin
                   frame_end = 1'b1;
                   state_nxt = ST_LATCH;
                 end
      ST_LATCH:  state_nxt = ST_WAIT;
      default:   state_nxt = ST_SYNC;
    endcase
  end

  // Accumulator stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_xmin <= X_IDLE;
      acc_xmax <= '0;
      acc_ymin <= Y_IDLE;
      acc_ymax <= '0;
      acc_cnt  <= '0;
    end else if (acc_clr) begin
      acc_xmin <= X_IDLE;
      acc_xmax <= '0;
      acc_ymin <= Y_IDLE;
      acc_ymax <= '0;
      acc_cnt  <= '0;
    end else if (hit) begin
      if (x < acc_xmin) acc_xmin <= x;
      if (x > acc_xmax) acc_xmax <= x;
      if (y < acc_ymin) acc_ymin <= y;
      if (y > acc_ymax) acc_ymax <= y;
      if (acc_cnt != CNT_MAX) acc_cnt <= acc_cnt + 1'b1;
    end
  end

  // Result stage: loaded on the edge that enters LATCH, so the new values
  // are visible in the same cycle as frame_done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bbox_xmin    <= X_IDLE;
      bbox_xmax    <= '0;
      bbox_ymin    <= Y_IDLE;
      bbox_ymax    <= '0;
      bbox_pix_cnt <= '0;
      bbox_valid   <= 1'b0;
    end else if (frame_end) begin
      bbox_pix_cnt <= acc_cnt;
      if (acc_cnt >= CNT_MIN) begin
        bbox_xmin  <= acc_xmin;
        bbox_xmax  <= acc_xmax;
        bbox_ymin  <= acc_ymin;
        bbox_ymax  <= acc_ymax;
        bbox_valid <= 1'b1;
      end else begin
`ifdef VIP_BBOX_HOLD_EN
        bbox_valid <= bbox_valid;
`else
        bbox_xmin  <= X_IDLE;
        bbox_xmax  <= '0;
        bbox_ymin  <= Y_IDLE;
        bbox_ymax  <= '0;
        bbox_valid <= 1'b0;
`endif
      end
    end
  end

  // Pass-through stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      post_frame_vsync <= 1'b0;
      post_frame_href  <= 1'b0;
      post_frame_clken <= 1'b0;
      post_img_Bit     <= 1'b0;
    end else begin
      post_frame_vsync <= per_frame_vsync;
      post_frame_href  <= per_frame_href;
      post_frame_clken <= per_frame_clken;
      post_img_Bit     <= per_img_Bit;
    end
  end

endmodule

// File: tb/tb_vip_bit_bbox_detector.sv
// Directed testbench for vip_bit_bbox_detector on a reduced 64x48 image
// (EDGE=10, MIN_PIX=64). A second instance with MIN_PIX=1 shares the inputs
// so a single-pixel frame can be seen as a valid box.
module tb_vip_bit_bbox_detector;

  localparam int IMG_W   = 64;
  localparam int IMG_H   = 48;
  localparam int EDGE    = 10;
  localparam int MIN_PIX = 64;
  localparam int XW      = 11;
  localparam int YW      = 10;

`ifdef VIP_BBOX_HOLD_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  logic vsync, href, clken, pix;

  logic          post_frame_vsync, post_frame_href, post_frame_clken, post_img_Bit;
  logic [XW-1:0] bbox_xmin, bbox_xmax;
  logic [YW-1:0] bbox_ymin, bbox_ymax;
  logic [19:0]   bbox_pix_cnt;
  logic          bbox_valid, frame_done;

  logic          d1_vs, d1_hs, d1_ce, d1_bit;
  logic [XW-1:0] d1_xmin, d1_xmax;
  logic [YW-1:0] d1_ymin, d1_ymax;
  logic [19:0]   d1_cnt;
  logic          d1_valid, d1_done;

  int total = 0;
  int bad   = 0;
  int fd_seen = 0;

  always #5 clk = ~clk;

  vip_bit_bbox_detector #(
    .IMG_W(IMG_W), .IMG_H(IMG_H), .EDGE(EDGE), .MIN_PIX(MIN_PIX), .XW(XW), .YW(YW)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .per_frame_vsync  (vsync),
    .per_frame_href   (href),
    .per_frame_clken  (clken),
    .per_img_Bit      (pix),
    .post_frame_vsync (post_frame_vsync),
    .post_frame_href  (post_frame_href),
    .post_frame_clken (post_frame_clken),
    .post_img_Bit     (post_img_Bit),
    .bbox_xmin        (bbox_xmin),
    .bbox_xmax        (bbox_xmax),
    .bbox_ymin        (bbox_ymin),
    .bbox_ymax        (bbox_ymax),
    .bbox_pix_cnt     (bbox_pix_cnt),
    .bbox_valid       (bbox_valid),
    .frame_done       (frame_done)
  );

  vip_bit_bbox_detector #(
    .IMG_W(IMG_W), .IMG_H(IMG_H), .EDGE(EDGE), .MIN_PIX(1), .XW(XW), .YW(YW)
  ) dut_min1 (
    .clk              (clk),
    .rst_n            (rst_n),
    .per_frame_vsync  (vsync),
    .per_frame_href   (href),
    .per_frame_clken  (clken),
    .per_img_Bit      (pix),
    .post_frame_vsync (d1_vs),
    .post_frame_href  (d1_hs),
    .post_frame_clken (d1_ce),
    .post_img_Bit     (d1_bit),
    .bbox_xmin        (d1_xmin),
    .bbox_xmax        (d1_xmax),
    .bbox_ymin        (d1_ymin),
    .bbox_ymax        (d1_ymax),
    .bbox_pix_cnt     (d1_cnt),
    .bbox_valid       (d1_valid),
    .frame_done       (d1_done)
  );

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
    $fatal(1, "timeout");
  end

  // One clock: inputs set before this call are consumed at the edge;
  // outputs are read 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
    if (frame_done === 1'b1) fd_seen++;
  endtask

  function automatic logic pix_val(input int mode, input int x, input int y);
    case (mode)
      0:       return (x == 40 && y == 20);
      1:       return (x >= 20 && x <= 35 && y >= 30 && y <= 37);
      2:       return (x < 10 || y < 10);
      default: return 1'b1;
    endcase
  endfunction

  // Drives one frame of nlines lines, npix qualified pixels per line.
  // rst_line >= 0 pulses reset at the start of that line.
  task automatic drive_frame(input int mode, input int npix, input int nlines,
                             input bit gaps, input int rst_line,
                             output int fd_cnt, output logic vld_before,
                             output logic done_next);
    fd_seen = 0;
    vsync = 1'b1; href = 1'b0; clken = 1'b0; pix = 1'b0;
    repeat (3) step();
    for (int ly = 0; ly < nlines; ly++) begin
      int px;
      if (ly == rst_line) begin
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
      end
      px = 0;
      while (px < npix) begin
        href  = 1'b1;
        clken = gaps ? ($urandom_range(3) != 0) : 1'b1;
        pix   = clken ? pix_val(mode, px, ly) : 1'($urandom_range(1));
        step();
        if (clken) px++;
      end
      href = 1'b0; clken = 1'b0; pix = 1'b0;
      repeat (2) step();
    end
    vsync      = 1'b0;
    vld_before = bbox_valid;
    step();
    done_next = frame_done;
    repeat (4) step();
    fd_cnt = fd_seen;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    vsync = 1'b0; href = 1'b1; clken = 1'b1; pix = 1'b1;
    repeat (3) step();
    total++; if (bbox_xmin !== 11'd63) begin bad++; $display("FAIL reset_xmin got=%0d want=63", bbox_xmin); end
    total++; if (bbox_xmax !== 11'd0) begin bad++; $display("FAIL reset_xmax got=%0d want=0", bbox_xmax); end
    total++; if (bbox_ymin !== 10'd47) begin bad++; $display("FAIL reset_ymin got=%0d want=47", bbox_ymin); end
    total++; if (bbox_ymax !== 10'd0) begin bad++; $display("FAIL reset_ymax got=%0d want=0", bbox_ymax); end
    total++; if (bbox_pix_cnt !== 20'd0) begin bad++; $display("FAIL reset_cnt got=%0d want=0", bbox_pix_cnt); end
    total++; if (bbox_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", bbox_valid); end
    total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", frame_done); end
    total++; if ({post_frame_vsync, post_frame_href, post_frame_clken, post_img_Bit} !== 4'b0000) begin
      bad++; $display("FAIL reset_post got=%b want=0000",
                      {post_frame_vsync, post_frame_href, post_frame_clken, post_img_Bit});
    end
    href = 1'b0; clken = 1'b0; pix = 1'b0;
    rst_n = 1'b1;
    repeat (3) step();
    total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL reset_done_after got=%b want=0", frame_done); end
  endtask

  task automatic test_single_pixel();
    int fdc; logic vb, dn;
    drive_frame(0, IMG_W, IMG_H, 1'b0, -1, fdc, vb, dn);
    total++; if (fdc !== 1) begin bad++; $display("FAIL single_done_count got=%0d want=1", fdc); end
    total++; if (dn !== 1'b1) begin bad++; $display("FAIL single_done_latency got=%b want=1", dn); end
    total++; if (bbox_pix_cnt !== 20'd1) begin bad++; $display("FAIL single_cnt got=%0d want=1", bbox_pix_cnt); end
    total++; if (bbox_valid !== 1'b0) begin bad++; $display("FAIL single_valid got=%b want=0", bbox_valid); end
    total++; if (bbox_xmin !== 11'd63) begin bad++; $display("FAIL single_xmin got=%0d want=63", bbox_xmin); end
    total++; if (bbox_ymax !== 10'd0) begin bad++; $display("FAIL single_ymax got=%0d want=0", bbox_ymax); end
    total++; if (d1_xmin !== 11'd40) begin bad++; $display("FAIL single_m1_xmin got=%0d want=40", d1_xmin); end
    total++; if (d1_xmax !== 11'd40) begin bad++; $display("FAIL single_m1_xmax got=%0d want=40", d1_xmax); end
    total++; if (d1_ymin !== 10'd20) begin bad++; $display("FAIL single_m1_ymin got=%0d want=20", d1_ymin); end
    total++; if (d1_ymax !== 10'd20) begin bad++; $display("FAIL single_m1_ymax got=%0d want=20", d1_ymax); end
    total++; if (d1_cnt !== 20'd1) begin bad++; $display("FAIL single_m1_cnt got=%0d want=1", d1_cnt); end
    total++; if (d1_valid !== 1'b1) begin bad++; $display("FAIL single_m1_valid got=%b want=1", d1_valid); end
  endtask

  task automatic test_rectangle();
    int fdc; logic vb, dn;
    drive_frame(1, IMG_W, IMG_H, 1'b1, -1, fdc, vb, dn);
    total++; if (vb !== 1'b0) begin bad++; $display("FAIL rect_valid_before_fall got=%b want=0", vb); end
    total++; if (dn !== 1'b1) begin bad++; $display("FAIL rect_done_latency got=%b want=1", dn); end
    total++; if (fdc !== 1) begin bad++; $display("FAIL rect_done_count got=%0d want=1", fdc); end
    total++; if (bbox_xmin !== 11'd20) begin bad++; $display("FAIL rect_xmin got=%0d want=20", bbox_xmin); end
    total++; if (bbox_xmax !== 11'd35) begin bad++; $display("FAIL rect_xmax got=%0d want=35", bbox_xmax); end
    total++; if (bbox_ymin !== 10'd30) begin bad++; $display("FAIL rect_ymin got=%0d want=30", bbox_ymin); end
    total++; if (bbox_ymax !== 10'd37) begin bad++; $display("FAIL rect_ymax got=%0d want=37", bbox_ymax); end
    total++; if (bbox_pix_cnt !== 20'd128) begin bad++; $display("FAIL rect_cnt got=%0d want=128", bbox_pix_cnt); end
    total++; if (bbox_valid !== 1'b1) begin bad++; $display("FAIL rect_valid got=%b want=1", bbox_valid); end
  endtask

  task automatic test_border();
    int fdc; logic vb, dn;
    drive_frame(2, IMG_W, IMG_H, 1'b0, -1, fdc, vb, dn);
    total++; if (fdc !== 1) begin bad++; $display("FAIL border_done_count got=%0d want=1", fdc); end
    total++; if (bbox_pix_cnt !== 20'd0) begin bad++; $display("FAIL border_cnt got=%0d want=0", bbox_pix_cnt); end
    total++; if (bbox_valid !== HOLD) begin bad++; $display("FAIL border_valid got=%b want=%b", bbox_valid, HOLD); end
    total++; if (bbox_xmin !== (HOLD ? 11'd20 : 11'd63)) begin
      bad++; $display("FAIL border_xmin got=%0d want=%0d", bbox_xmin, HOLD ? 20 : 63); end
    total++; if (bbox_xmax !== (HOLD ? 11'd35 : 11'd0)) begin
      bad++; $display("FAIL border_xmax got=%0d want=%0d", bbox_xmax, HOLD ? 35 : 0); end
    total++; if (bbox_ymin !== (HOLD ? 10'd30 : 10'd47)) begin
      bad++; $display("FAIL border_ymin got=%0d want=%0d", bbox_ymin, HOLD ? 30 : 47); end
    total++; if (bbox_ymax !== (HOLD ? 10'd37 : 10'd0)) begin
      bad++; $display("FAIL border_ymax got=%0d want=%0d", bbox_ymax, HOLD ? 37 : 0); end
  endtask

  task automatic test_reset_mid_frame();
    int fdc; logic vb, dn;
    drive_frame(1, IMG_W, IMG_H, 1'b0, 33, fdc, vb, dn);
    total++; if (fdc !== 0) begin bad++; $display("FAIL rstmid_done_count got=%0d want=0", fdc); end
    total++; if (dn !== 1'b0) begin bad++; $display("FAIL rstmid_done got=%b want=0", dn); end
    total++; if (bbox_valid !== 1'b0) begin bad++; $display("FAIL rstmid_valid got=%b want=0", bbox_valid); end
    total++; if (bbox_xmin !== 11'd63) begin bad++; $display("FAIL rstmid_xmin got=%0d want=63", bbox_xmin); end
    total++; if (bbox_pix_cnt !== 20'd0) begin bad++; $display("FAIL rstmid_cnt got=%0d want=0", bbox_pix_cnt); end
    drive_frame(1, IMG_W, IMG_H, 1'b0, -1, fdc, vb, dn);
    total++; if (fdc !== 1) begin bad++; $display("FAIL rstmid_f2_done_count got=%0d want=1", fdc); end
    total++; if ({bbox_xmin, bbox_xmax} !== {11'd20, 11'd35}) begin
      bad++; $display("FAIL rstmid_f2_x got=%0d,%0d want=20,35", bbox_xmin, bbox_xmax); end
    total++; if ({bbox_ymin, bbox_ymax} !== {10'd30, 10'd37}) begin
      bad++; $display("FAIL rstmid_f2_y got=%0d,%0d want=30,37", bbox_ymin, bbox_ymax); end
    total++; if (bbox_pix_cnt !== 20'd128) begin bad++; $display("FAIL rstmid_f2_cnt got=%0d want=128", bbox_pix_cnt); end
    total++; if (bbox_valid !== 1'b1) begin bad++; $display("FAIL rstmid_f2_valid got=%b want=1", bbox_valid); end
  endtask

  // All-ones frame with 70 pixels x 52 lines: columns past 63 and lines
  // past 47 fall outside the image. Box 10..63 x 10..47, 54*38 = 2052.
  task automatic test_saturation();
    int fdc; logic vb, dn;
    drive_frame(3, 70, 52, 1'b0, -1, fdc, vb, dn);
    total++; if (fdc !== 1) begin bad++; $display("FAIL sat_done_count got=%0d want=1", fdc); end
    total++; if (bbox_xmin !== 11'd10) begin bad++; $display("FAIL sat_xmin got=%0d want=10", bbox_xmin); end
    total++; if (bbox_xmax !== 11'd63) begin bad++; $display("FAIL sat_xmax got=%0d want=63", bbox_xmax); end
    total++; if (bbox_ymin !== 10'd10) begin bad++; $display("FAIL sat_ymin got=%0d want=10", bbox_ymin); end
    total++; if (bbox_ymax !== 10'd47) begin bad++; $display("FAIL sat_ymax got=%0d want=47", bbox_ymax); end
    total++; if (bbox_pix_cnt !== 20'd2052) begin bad++; $display("FAIL sat_cnt got=%0d want=2052", bbox_pix_cnt); end
    total++; if (bbox_valid !== 1'b1) begin bad++; $display("FAIL sat_valid got=%b want=1", bbox_valid); end
  endtask

  // After each edge the outputs must show what was driven before it, and
  // must keep showing it after the inputs change again.
  task automatic test_pass_through();
    logic [3:0] exp;
    for (int i = 0; i < 200; i++) begin
      {vsync, href, clken, pix} = 4'($urandom);
      step();
      exp = {vsync, href, clken, pix};
      {vsync, href, clken, pix} = 4'($urandom);
      #1;
      total++;
      if ({post_frame_vsync, post_frame_href, post_frame_clken, post_img_Bit, d1_vs, d1_hs, d1_ce, d1_bit}
          !== {exp, exp}) begin
        bad++;
        $display("FAIL pass_through cycle=%0d got=%b want=%b", i,
                 {post_frame_vsync, post_frame_href, post_frame_clken, post_img_Bit,
                  d1_vs, d1_hs, d1_ce, d1_bit}, {exp, exp});
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_pixel();
    test_rectangle();
    test_border();
    test_reset_mid_frame();
    test_saturation();
    test_pass_through();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
